clock_time_ctrl: RTL and testbench

//  Timekeeping controller for the digital clock. Consumes the divider's 1 Hz square wave
//  (a level signal in the clk domain) and advances BCD hh:mm:ss.

---
 rtl/clock_time_ctrl.sv | 174 +++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: timekeeping and time-setting controller for the digital clock.
// Counts BCD hh:mm:ss from the divider's 1 Hz square wave and runs a three-state
// mode FSM (RUN / SET_HR / SET_MIN) driven by two debounced buttons.
// Optional feature macro: CHIME_CTRL_EN adds the hourly chime port and its timer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | time advances on each 1 Hz rise, sec_tick pulses
// ST_SET_HR  | time frozen, btn_inc advances hours (no carry)
// ST_SET_MIN | time frozen, btn_inc advances minutes (no carry); exit zeroes sec
module clock_time_ctrl #(
  parameter int HOUR_24    = 1,
  parameter int CHIME_SECS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sq_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       sec_tick,
  output logic       blink_hr,
  output logic       blink_min,
  output logic [1:0] mode_st
`ifdef CHIME_CTRL_EN
  ,
  output logic       chime
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_t;

  localparam logic [7:0] HR_RESET = (HOUR_24 != 0) ? 8'h00 : 8'h12;

  // Chime length outside 1..15 cannot be held by the 4-bit timer.
  if (CHIME_SECS < 1 || CHIME_SECS > 15) begin : g_bad_chime
    $error("CHIME_SECS must be in 1..15");
  end

  state_t state, state_nxt;
  logic   sq_q, mode_q, inc_q;
  logic   sq_rise, mode_rise, inc_rise;
  logic   count_sec, inc_hr_ev, inc_min_ev, clear_sec;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_60(input logic [7:0] v);
    inc_60 = (v == 8'h59) ? 8'h00 : bcd_inc(v);
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (HOUR_24 != 0) inc_hour = (v == 8'h23) ? 8'h00 : bcd_inc(v);
    else              inc_hour = (v == 8'h12) ? 8'h01 : bcd_inc(v);
  endfunction

  assign sq_rise   = sq_1hz   & ~sq_q;
  assign mode_rise = btn_mode & ~mode_q;
  assign inc_rise  = btn_inc  & ~inc_q;
  assign mode_st   = state;

  // Input history for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q   <= 1'b0;
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      sq_q   <= sq_1hz;
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
    end
  end

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Next state and datapath strobes; a mode rise always beats a same-cycle inc.
  always_comb begin
    state_nxt  = state;
    count_sec  = 1'b0;
    inc_hr_ev  = 1'b0;
    inc_min_ev = 1'b0;
    clear_sec  = 1'b0;
    case (state)
      ST_RUN: begin
        if (mode_rise) state_nxt = ST_SET_HR;
        else           count_sec = sq_rise;
      end
      ST_SET_HR: begin
        if (mode_rise)     state_nxt = ST_SET_MIN;
        else if (inc_rise) inc_hr_ev = 1'b1;
      end
      ST_SET_MIN: begin
        if (mode_rise) begin
          state_nxt = ST_RUN;
          clear_sec = 1'b1;
        end else if (inc_rise) begin
          inc_min_ev = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Time registers: full carry chain in one update while running, no carry while setting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr_bcd   <= HR_RESET;
      min_bcd  <= 8'h00;
      sec_bcd  <= 8'h00;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= count_sec;
      if (count_sec) begin
        sec_bcd <= inc_60(sec_bcd);
        if (sec_bcd == 8'h59) begin
          min_bcd <= inc_60(min_bcd);
          if (min_bcd == 8'h59) hr_bcd <= inc_hour(hr_bcd);
        end
      end
      if (inc_hr_ev)  hr_bcd  <= inc_hour(hr_bcd);
      if (inc_min_ev) min_bcd <= inc_60(min_bcd);
      if (clear_sec)  sec_bcd <= 8'h00;
    end
  end

  // Blink enables follow the low half of the 1 Hz wave in the matching set state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_hr  <= 1'b0;
      blink_min <= 1'b0;
    end else begin
      blink_hr  <= (state_nxt == ST_SET_HR)  & ~sq_1hz;
      blink_min <= (state_nxt == ST_SET_MIN) & ~sq_1hz;
    end
  end

`ifdef CHIME_CTRL_EN
  localparam logic [3:0] CHIME_LEN = CHIME_SECS[3:0];
  logic [3:0] chime_cnt;

  // Hourly chime: starts on the mm:ss roll to 00:00, lasts CHIME_LEN counted seconds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chime     <= 1'b0;
      chime_cnt <= 4'd0;
    end else if (state_nxt != ST_RUN) begin
      chime     <= 1'b0;
      chime_cnt <= 4'd0;
    end else if (count_sec) begin
      if (min_bcd == 8'h59 && sec_bcd == 8'h59) begin
        chime     <= 1'b1;
        chime_cnt <= CHIME_LEN;
      end else if (chime_cnt != 4'd0) begin
        chime_cnt <= chime_cnt - 4'd1;
        if (chime_cnt == 4'd1) chime <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: a 24-hour and a 12-hour instance share the same
// stimulus and are compared against a seconds-arithmetic reference model.
module tb_clock_time_ctrl;

  localparam int CHIME_SECS = 2;

  logic       clk = 1'b0;
  logic       rst_n, sq_1hz, btn_mode, btn_inc;
  logic [7:0] hr_a, min_a, sec_a, hr_b, min_b, sec_b;
  logic       tick_a, tick_b, bhr_a, bmin_a, bhr_b, bmin_b;
  logic [1:0] mode_a, mode_b;
`ifdef CHIME_CTRL_EN
  logic       chime_a, chime_b;
`endif

  always #5 clk = ~clk;

  clock_time_ctrl #(.HOUR_24(1), .CHIME_SECS(CHIME_SECS)) dut_a (
    .clk(clk), .rst_n(rst_n), .sq_1hz(sq_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hr_bcd(hr_a), .min_bcd(min_a), .sec_bcd(sec_a), .sec_tick(tick_a),
    .blink_hr(bhr_a), .blink_min(bmin_a), .mode_st(mode_a)
`ifdef CHIME_CTRL_EN
    , .chime(chime_a)
`endif
  );

  clock_time_ctrl #(.HOUR_24(0), .CHIME_SECS(CHIME_SECS)) dut_b (
    .clk(clk), .rst_n(rst_n), .sq_1hz(sq_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hr_bcd(hr_b), .min_bcd(min_b), .sec_bcd(sec_b), .sec_tick(tick_b),
    .blink_hr(bhr_b), .blink_min(bmin_b), .mode_st(mode_b)
`ifdef CHIME_CTRL_EN
    , .chime(chime_b)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: 0 RUN, 1 SET_HR, 2 SET_MIN
  int m_mode, a_h, b_h, m_m, m_s, chime_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_mode = 0; a_h = 0; b_h = 12; m_m = 0; m_s = 0; chime_left = 0;
  endtask

  task automatic model_tick();
    int t;
    if (m_mode != 0) return;
    t   = (a_h * 3600 + m_m * 60 + m_s + 1) % 86400;
    a_h = t / 3600;
    t   = ((b_h % 12) * 3600 + m_m * 60 + m_s + 1) % 43200;
    b_h = (t / 3600 == 0) ? 12 : t / 3600;
    m_m = (t / 60) % 60;
    m_s = t % 60;
    if (m_m == 0 && m_s == 0) chime_left = CHIME_SECS;
    else if (chime_left > 0)  chime_left--;
  endtask

  task automatic model_press(input bit m, input bit i);
    if (m) begin
      case (m_mode)
        0: begin m_mode = 1; chime_left = 0; end
        1: m_mode = 2;
        default: begin m_mode = 0; m_s = 0; end
      endcase
    end else if (i) begin
      if (m_mode == 1) begin
        a_h = (a_h + 1) % 24;
        b_h = (b_h % 12) + 1;
      end else if (m_mode == 2) begin
        m_m = (m_m + 1) % 60;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".hr24"},  hr_a,  to_bcd(a_h));
    chk({tag, ".hr12"},  hr_b,  to_bcd(b_h));
    chk({tag, ".min"},   min_a, to_bcd(m_m));
    chk({tag, ".min12"}, min_b, to_bcd(m_m));
    chk({tag, ".sec"},   sec_a, to_bcd(m_s));
    chk({tag, ".sec12"}, sec_b, to_bcd(m_s));
    chk({tag, ".mode"},  mode_a, m_mode);
    chk({tag, ".mode12"}, mode_b, m_mode);
    chk({tag, ".tick_idle"}, {tick_a, tick_b}, 0);
    chk({tag, ".blink"}, {bhr_a, bmin_a, bhr_b, bmin_b},
        {m_mode == 1, m_mode == 2, m_mode == 1, m_mode == 2});
`ifdef CHIME_CTRL_EN
    chk({tag, ".chime"}, chime_a, chime_left > 0);
`endif
  endtask

  task automatic do_tick(input string tag);
    int hi, lo, cnt_a, cnt_b;
    hi = $urandom_range(3, 8);
    lo = $urandom_range(3, 8);
    cnt_a = 0; cnt_b = 0;
    sq_1hz = 1'b1;
    repeat (hi) begin
      @(negedge clk);
      cnt_a += int'(tick_a);
      cnt_b += int'(tick_b);
    end
    chk({tag, ".blink_hi"}, {bhr_a, bmin_a, bhr_b, bmin_b}, 0);
    sq_1hz = 1'b0;
    repeat (lo) begin
      @(negedge clk);
      cnt_a += int'(tick_a);
      cnt_b += int'(tick_b);
    end
    chk({tag, ".tick_cnt"},   cnt_a, (m_mode == 0) ? 1 : 0);
    chk({tag, ".tick_cnt12"}, cnt_b, (m_mode == 0) ? 1 : 0);
    model_tick();
    check_all(tag);
  endtask

  task automatic press(input string tag, input bit m, input bit i, input int hold);
    bit was_run;
    was_run  = (m_mode == 0);
    btn_mode = m;
    btn_inc  = i;
    cycles(1);
`ifdef CHIME_CTRL_EN
    if (m && was_run) chk({tag, ".chime_clr"}, chime_a, 0);
`endif
    if (hold > 1) cycles(hold - 1);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cycles(2);
    model_press(m, i);
    check_all(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int op, guard;
    rst_n = 1'b0; sq_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    cycles(3);
    model_reset();
    check_all("reset_hold");
    rst_n = 1'b1;
    cycles(2);
    check_all("reset");

    // preload 23:59:58 (12h instance: 11:59:58) through the set path
    press("enter_hr", 1, 0, 2);
    for (int k = 0; k < 23; k++) press("pre_hr", 0, 1, 2);
    press("enter_min", 1, 0, 2);
    for (int k = 0; k < 59; k++) press("pre_min", 0, 1, 2);
    press("run", 1, 0, 2);
    for (int k = 0; k < 58; k++) do_tick("pre_sec");
    chk("preload", {hr_a, min_a, sec_a}, 24'h235958);
    do_tick("to_59");
    chk("t_235959", {hr_a, min_a, sec_a}, 24'h235959);
    do_tick("midnight");
    chk("t_000000", {hr_a, min_a, sec_a}, 24'h000000);
    chk("t12_120000", {hr_b, min_b, sec_b}, 24'h120000);
    for (int k = 0; k < 3; k++) do_tick("chime_len");

    // 12h roll 12:59:59 -> 01:00:00
    press("h12_hr", 1, 0, 2);
    press("h12_min", 1, 0, 2);
    for (int k = 0; k < 59; k++) press("h12_minc", 0, 1, 2);
    press("h12_run", 1, 0, 2);
    for (int k = 0; k < 59; k++) do_tick("h12_sec");
    chk("t12_125959", {hr_b, min_b, sec_b}, 24'h125959);
    do_tick("h12_roll");
    chk("t12_010000", {hr_b, min_b, sec_b}, 24'h010000);
    do_tick("chime_mid");
    press("chime_abort", 1, 0, 1);

    // set sequence: hr 21 + 5 -> 02, frozen time, min 59 -> 00, sec zeroed on exit
    guard = 0;
    while (a_h != 21 && guard < 30) begin
      press("to_21", 0, 1, 2);
      guard++;
    end
    chk("hr_21", hr_a, 8'h21);
    for (int k = 0; k < 5; k++) press("hr_inc", 0, 1, $urandom_range(1, 4));
    chk("hr_02", hr_a, 8'h02);
    for (int k = 0; k < 3; k++) do_tick("frozen");
    press("to_min", 1, 0, 2);
    guard = 0;
    while (m_m != 59 && guard < 70) begin
      press("to_59", 0, 1, 2);
      guard++;
    end
    press("min_wrap", 0, 1, 2);
    chk("min_00_hr_02", {hr_a, min_a}, 16'h0200);
    press("back_run", 1, 0, 2);
    chk("sec_zero", sec_a, 8'h00);

    // same-cycle mode+inc in SET_HR, then a long inc hold
    press("sh_hr", 1, 0, 2);
    press("both", 1, 1, 3);
    press("exit", 1, 0, 2);
    press("sh_hr2", 1, 0, 2);
    press("hold_inc", 0, 1, 1000);
    press("sh_min", 1, 0, 2);
    press("sh_run", 1, 0, 2);

    // random operations
    for (int k = 0; k < 200; k++) begin
      op = $urandom_range(0, 9);
      if (op < 5)       do_tick("rnd_tick");
      else if (op < 7)  press("rnd_mode", 1, 0, $urandom_range(1, 6));
      else if (op < 9)  press("rnd_inc", 0, 1, $urandom_range(1, 6));
      else              press("rnd_both", 1, 1, $urandom_range(1, 6));
    end

    // asynchronous reset mid-operation
    press("pre_rst", 1, 0, 2);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("async_rst", {hr_a, min_a, sec_a, 6'(mode_a), hr_b}, {24'h000000, 6'd0, 8'h12});
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    check_all("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
